// File: rtl/i3c_phy_io.sv
// I3C pad-side PHY: drives SCL/SDA pad enables, filters pad inputs,
// detects START/Sr/STOP, tracks bus free/available/idle timing.
module i3c_phy_io #(
  parameter int unsigned FiltCycles = 2,
  parameter int unsigned TimerW     = 20
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              phy_en_i,
  input  logic              ctrl_scl_i,
  input  logic              ctrl_sda_i,
  input  logic              sel_od_pp_i,
  output logic              ctrl_scl_o,
  output logic              ctrl_sda_o,
  input  logic              scl_pad_i,
  input  logic              sda_pad_i,
  output logic              scl_pad_o,
  output logic              scl_pad_oe_o,
  output logic              sda_pad_o,
  output logic              sda_pad_oe_o,
  input  logic [TimerW-1:0] t_bus_free_i,
  input  logic [TimerW-1:0] t_bus_available_i,
  input  logic [TimerW-1:0] t_bus_idle_i,
  output logic              start_det_o,
  output logic              rstart_det_o,
  output logic              stop_det_o,
  output logic              bus_busy_o,
  output logic              bus_free_o,
  output logic              bus_available_o,
  output logic              bus_idle_o,
  output logic              sda_mismatch_o
);

  localparam int unsigned CntW =
    (FiltCycles > 0) ? $clog2(FiltCycles + 1) : 1;

  logic [1:0] pad_raw;
  logic [1:0] sync_q1;
  logic [1:0] sync_q2;
  logic [1:0] filt;

  assign pad_raw = {sda_pad_i, scl_pad_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q1 <= 2'b11;
      sync_q2 <= 2'b11;
    end else begin
      sync_q1 <= pad_raw;
      sync_q2 <= sync_q1;
    end
  end

  if (FiltCycles == 0) begin : g_nofilt
    assign filt = sync_q2;
  end else begin : g_filt
    for (genvar i = 0; i < 2; i++) begin : g_line
      logic [CntW-1:0] cnt_q;
      logic            filt_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_q  <= '0;
          filt_q <= 1'b1;
        end else if (sync_q2[i] == filt_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CntW'(FiltCycles - 1)) begin
          cnt_q  <= '0;
          filt_q <= ~filt_q;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end

      assign filt[i] = filt_q;
    end
  end

  logic scl_f;
  logic sda_f;

  assign scl_f      = filt[0];
  assign sda_f      = filt[1];
  assign ctrl_scl_o = scl_f;
  assign ctrl_sda_o = sda_f;

  logic scl_o_d;
  logic scl_oe_d;
  logic sda_o_d;
  logic sda_oe_d;

  always_comb begin
    scl_o_d  = 1'b0;
    scl_oe_d = 1'b0;
    sda_o_d  = 1'b0;
    sda_oe_d = 1'b0;
    if (phy_en_i) begin
      scl_o_d  = ctrl_scl_i;
      scl_oe_d = 1'b1;
      if (sel_od_pp_i) begin
        sda_o_d  = ctrl_sda_i;
        sda_oe_d = 1'b1;
      end else begin
        sda_oe_d = ~ctrl_sda_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_pad_o    <= 1'b0;
      scl_pad_oe_o <= 1'b0;
      sda_pad_o    <= 1'b0;
      sda_pad_oe_o <= 1'b0;
    end else begin
      scl_pad_o    <= scl_o_d;
      scl_pad_oe_o <= scl_oe_d;
      sda_pad_o    <= sda_o_d;
      sda_pad_oe_o <= sda_oe_d;
    end
  end

  logic scl_q;
  logic sda_q;
  logic scl_hold;
  logic sda_fall;
  logic sda_rise;
  logic start_c;
  logic rstart_c;
  logic stop_c;
  logic sda_want1;
  logic mis_c;
  logic busy_d;

  // SCL must be high on both sides of the SDA edge, which also
  // rejects the case where both lines toggle together.
  assign scl_hold  = scl_f & scl_q;
  assign sda_fall  = sda_q & ~sda_f;
  assign sda_rise  = ~sda_q & sda_f;
  assign start_c   = scl_hold & sda_fall & ~bus_busy_o;
  assign rstart_c  = scl_hold & sda_fall & bus_busy_o;
  assign stop_c    = scl_hold & sda_rise;
  assign sda_want1 = ~sda_pad_oe_o | sda_pad_o;
  assign mis_c     = scl_f & ~scl_q & sda_want1 & ~sda_f;

  always_comb begin
    busy_d = bus_busy_o;
    unique case (1'b1)
      stop_c:  busy_d = 1'b0;
      start_c: busy_d = 1'b1;
      default: busy_d = bus_busy_o;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_q          <= 1'b1;
      sda_q          <= 1'b1;
      start_det_o    <= 1'b0;
      rstart_det_o   <= 1'b0;
      stop_det_o     <= 1'b0;
      sda_mismatch_o <= 1'b0;
      bus_busy_o     <= 1'b0;
    end else begin
      scl_q          <= scl_f;
      sda_q          <= sda_f;
      start_det_o    <= start_c;
      rstart_det_o   <= rstart_c;
      stop_det_o     <= stop_c;
      sda_mismatch_o <= mis_c;
      bus_busy_o     <= busy_d;
    end
  end

  logic [TimerW-1:0] timer_q;
  logic              timer_run;

  assign timer_run = ~bus_busy_o & scl_f & sda_f;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
    end else if (!timer_run || start_c) begin
      timer_q <= '0;
    end else if (timer_q != '1) begin
      timer_q <= timer_q + TimerW'(1);
    end
  end

  assign bus_free_o      = ~bus_busy_o & (timer_q >= t_bus_free_i);
  assign bus_available_o = ~bus_busy_o & (timer_q >= t_bus_available_i);
  assign bus_idle_o      = ~bus_busy_o & (timer_q >= t_bus_idle_i);

endmodule

// File: tb/tb_i3c_phy_io.sv
// Directed bench for i3c_phy_io with a masked-expectation scoreboard.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_i3c_phy_io;

  localparam int TW = 20;

  localparam logic [13:0] M_CSCL  = 14'h0001;
  localparam logic [13:0] M_CSDA  = 14'h0002;
  localparam logic [13:0] M_SCLO  = 14'h0004;
  localparam logic [13:0] M_SCLOE = 14'h0008;
  localparam logic [13:0] M_SDAO  = 14'h0010;
  localparam logic [13:0] M_SDAOE = 14'h0020;
  localparam logic [13:0] M_ST    = 14'h0040;
  localparam logic [13:0] M_RS    = 14'h0080;
  localparam logic [13:0] M_SP    = 14'h0100;
  localparam logic [13:0] M_BUSY  = 14'h0200;
  localparam logic [13:0] M_FREE  = 14'h0400;
  localparam logic [13:0] M_AVAIL = 14'h0800;
  localparam logic [13:0] M_IDLE  = 14'h1000;
  localparam logic [13:0] M_MIS   = 14'h2000;
  localparam logic [13:0] M_PADS  = 14'h003C;
  localparam logic [13:0] M_PULS  = 14'h21C0;
  localparam logic [13:0] M_ALL   = 14'h3FFF;

  logic clk;
  logic rst_ni;
  logic phy_en;
  logic ctrl_scl;
  logic ctrl_sda;
  logic sel_od_pp;
  logic ctrl_scl_o;
  logic ctrl_sda_o;
  logic scl_pad;
  logic sda_pad;
  logic scl_pad_o;
  logic scl_pad_oe_o;
  logic sda_pad_o;
  logic sda_pad_oe_o;
  logic [TW-1:0] t_free;
  logic [TW-1:0] t_avail;
  logic [TW-1:0] t_idle;
  logic start_det;
  logic rstart_det;
  logic stop_det;
  logic busy;
  logic bus_free;
  logic bus_avail;
  logic bus_idle;
  logic mismatch;
  logic [13:0] obs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [13:0] mask;
    logic [13:0] val;
  } exp_t;

  exp_t sb[$];

  i3c_phy_io #(.FiltCycles(2), .TimerW(TW)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .phy_en_i          (phy_en),
    .ctrl_scl_i        (ctrl_scl),
    .ctrl_sda_i        (ctrl_sda),
    .sel_od_pp_i       (sel_od_pp),
    .ctrl_scl_o        (ctrl_scl_o),
    .ctrl_sda_o        (ctrl_sda_o),
    .scl_pad_i         (scl_pad),
    .sda_pad_i         (sda_pad),
    .scl_pad_o         (scl_pad_o),
    .scl_pad_oe_o      (scl_pad_oe_o),
    .sda_pad_o         (sda_pad_o),
    .sda_pad_oe_o      (sda_pad_oe_o),
    .t_bus_free_i      (t_free),
    .t_bus_available_i (t_avail),
    .t_bus_idle_i      (t_idle),
    .start_det_o       (start_det),
    .rstart_det_o      (rstart_det),
    .stop_det_o        (stop_det),
    .bus_busy_o        (busy),
    .bus_free_o        (bus_free),
    .bus_available_o   (bus_avail),
    .bus_idle_o        (bus_idle),
    .sda_mismatch_o    (mismatch)
  );

  assign obs = {mismatch, bus_idle, bus_avail, bus_free,
                busy, stop_det, rstart_det, start_det,
                sda_pad_oe_o, sda_pad_o, scl_pad_oe_o,
                scl_pad_o, ctrl_sda_o, ctrl_scl_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_chk();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: observed none required entry");
    end else begin
      e = sb.pop_front();
      assert ((obs & e.mask) === (e.val & e.mask)) else begin
        errors++;
        $error("FAIL %s: observed %b required %b",
               e.tag, obs & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic expect_after(input string tag, input int n,
                              input logic [13:0] m,
                              input logic [13:0] v);
    exp_t e;
    e.tag  = tag;
    e.mask = m;
    e.val  = v;
    sb.push_back(e);
    if (n == 0) #1;
    else step(n);
    pop_chk();
  endtask

  initial begin
    rst_ni    = 1'b0;
    phy_en    = 1'b0;
    ctrl_scl  = 1'b1;
    ctrl_sda  = 1'b1;
    sel_od_pp = 1'b0;
    scl_pad   = 1'b1;
    sda_pad   = 1'b1;
    t_free    = TW'(5);
    t_avail   = TW'(8);
    t_idle    = TW'(20);

    expect_after("reset", 2, M_ALL, M_CSCL | M_CSDA);
    rst_ni = 1'b1;

    expect_after("free_t4", 4, M_FREE | M_AVAIL | M_IDLE | M_PADS, 14'h0);
    expect_after("free_t5", 1, M_FREE | M_AVAIL, M_FREE);
    expect_after("avail_t8", 3, M_FREE | M_AVAIL | M_IDLE,
                 M_FREE | M_AVAIL);
    expect_after("idle_t10", 2, M_IDLE | M_PADS, 14'h0);
    expect_after("idle_t20", 10, M_IDLE, M_IDLE);

    sda_pad = 1'b0;
    step(1);
    sda_pad = 1'b1;
    for (int i = 0; i < 6; i++)
      expect_after("glitch", 1, M_CSDA | M_ST, M_CSDA);

    sda_pad = 1'b0;
    expect_after("sda_lat3", 3, M_CSDA, M_CSDA);
    expect_after("sda_lat4", 1, M_CSDA | M_ST, 14'h0);
    expect_after("start", 1, M_ST | M_RS | M_SP | M_BUSY | M_FREE,
                 M_ST | M_BUSY);
    expect_after("start_end", 1, M_ST | M_BUSY, M_BUSY);

    scl_pad = 1'b0;
    expect_after("scl_low", 6, M_CSCL | M_PULS | M_BUSY, M_BUSY);
    sda_pad = 1'b1;
    expect_after("sda_hi_scl_lo", 6, M_CSDA | M_PULS | M_BUSY,
                 M_CSDA | M_BUSY);
    scl_pad = 1'b1;
    expect_after("scl_hi", 6, M_CSCL | M_PULS | M_BUSY,
                 M_CSCL | M_BUSY);
    sda_pad = 1'b0;
    step(4);
    expect_after("rstart", 1, M_ST | M_RS | M_SP | M_BUSY,
                 M_RS | M_BUSY);
    expect_after("rstart_end", 1, M_RS | M_BUSY, M_BUSY);
    sda_pad = 1'b1;
    step(4);
    expect_after("stop", 1, M_ST | M_RS | M_SP | M_BUSY | M_FREE, M_SP);
    expect_after("free_after_stop", 6, M_FREE | M_BUSY | M_SP, M_FREE);

    phy_en    = 1'b1;
    sel_od_pp = 1'b0;
    ctrl_sda  = 1'b0;
    ctrl_scl  = 1'b1;
    expect_after("od_low", 1, M_PADS, M_SCLO | M_SCLOE | M_SDAOE);
    ctrl_sda = 1'b1;
    expect_after("od_rel", 1, M_PADS, M_SCLO | M_SCLOE);
    sel_od_pp = 1'b1;
    expect_after("pp_hi", 1, M_PADS,
                 M_SCLO | M_SCLOE | M_SDAO | M_SDAOE);
    ctrl_sda = 1'b0;
    ctrl_scl = 1'b0;
    expect_after("pp_lo", 1, M_PADS, M_SCLOE | M_SDAOE);
    phy_en = 1'b0;
    expect_after("phy_off", 1, M_PADS, 14'h0);
    phy_en    = 1'b1;
    ctrl_scl  = 1'b1;
    sel_od_pp = 1'b0;
    ctrl_sda  = 1'b1;
    step(1);

    scl_pad = 1'b0;
    step(6);
    sda_pad = 1'b0;
    step(6);
    scl_pad = 1'b1;
    expect_after("mis_pre", 4, M_MIS, 14'h0);
    expect_after("mismatch", 1, M_MIS | M_ST | M_RS | M_SP, M_MIS);
    expect_after("mis_end", 1, M_MIS, 14'h0);

    scl_pad = 1'b0;
    step(6);
    ctrl_sda = 1'b0;
    scl_pad  = 1'b1;
    for (int i = 0; i < 6; i++)
      expect_after("no_mis", 1, M_MIS, 14'h0);

    sda_pad = 1'b1;
    step(4);
    expect_after("stop_idle", 1, M_SP | M_BUSY, M_SP);
    step(1);
    sda_pad = 1'b0;
    step(4);
    expect_after("start2", 1, M_ST | M_BUSY, M_ST | M_BUSY);
    step(3);

    #1;
    rst_ni  = 1'b0;
    sda_pad = 1'b1;
    scl_pad = 1'b1;
    expect_after("mid_reset", 0, M_ALL, M_CSCL | M_CSDA);
    @(negedge clk);
    rst_ni = 1'b1;
    expect_after("post_rst", 6,
                 M_BUSY | M_PULS | M_FREE | M_SCLOE | M_CSDA,
                 M_FREE | M_SCLOE | M_CSDA);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
